farm_sensor: RTL and testbench
==============================

# farm_sensor

Farm-road vehicle detector conditioner sitting directly upstream of the highway/farm-road traffic light controller. It synchronizes and debounces the raw loop-sensor input. It latches a qualified request and drives the controller's `C` input. It releases `C` once the farm road has been served and traffic has cleared.

## Interface
Parameters:
- `DEBOUNCE`, default 4: consecutive synchronized high samples required to qualify a car; legal range 1..255.
- `HOLD`, default 3: consecutive synchronized low samples during farm green before `C` is dropped; legal range 1..255.

Ports:
- `clock`  input  1  single system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high; clears every register, including the synchronizer.
- `sense`  input  1  raw, asynchronous, possibly bouncy loop-sensor level.
- `FG`  input  1  farm-green lamp from the traffic light controller; used as the "served" acknowledge.
- `C`  output  1  registered car-waiting request to the controller.
- `car_count`  output  8  registered count of qualified requests; present only with `CAR_COUNT_EN`.

## Operation
- **Synchronizer:** `sense` passes through two flops to give `s_sync`. Reset value is 0.
- **Counters:** one 8-bit counter `cnt` is shared between debounce and gap timing.
- **FSM:** 2-bit, four states. Reset state is IDLE, with `cnt`=0, `C`=0 and `car_count`=0.
- **IDLE** (`C`=0):
  - `s_sync`=1 → go to QUALIFY with `cnt`=1.
  - Otherwise stay.
- **QUALIFY** (`C`=0):
  - `s_sync`=0 → go to IDLE with `cnt`=0.
  - Else if `cnt`==`DEBOUNCE` → go to REQUEST, `C`←1.
  - Else `cnt`++.
- **REQUEST** (`C`=1):
  - The request is latched; `s_sync` is ignored, so a car that briefly leaves the loop keeps its request.
  - `FG`=1 → go to SERVE with `cnt`=0.
- **SERVE** (`C`=1), evaluated in this priority order:
  1. `FG`=0 → go to IDLE, `C`←0. This covers a controller time-out; a car still present re-qualifies from IDLE.
  2. `s_sync`=1 → `cnt`=0.
  3. `s_sync`=0 and `cnt`==`HOLD`-1 → go to IDLE, `C`←0.
  4. Otherwise `cnt`++.
- **Arithmetic:**
  - `cnt` never exceeds 255 and never wraps, given the legal parameter range.
  - `DEBOUNCE` or `HOLD` of 0 is illegal. The bench flags it with an elaboration-time `$error`.
- **Simultaneous events:**
  - `reset` overrides everything.
  - In REQUEST, an `FG` already high on the entry cycle is acted on at the next edge.
  - `FG` high while the FSM is in IDLE or QUALIFY is ignored.

## Timing
- **Rising edge of `C`:**
  - `sense` rises before edge 1 and stays high. `C`=1 is first visible after edge `DEBOUNCE`+3.
  - With default parameters, `C` rises after edge 7.
- **Falling edge of `C` (car leaves):**
  - Preconditions: SERVE, `FG`=1, and `sense` falls before edge 1. `C`=0 is visible after edge `HOLD`+2.
  - With `HOLD`=3 this is after edge 5.
- **Falling edge of `C` (`FG` drops):** `C` falls one edge after `FG`=0 is sampled in SERVE.
- **Debounce restart:** a high pulse on `s_sync` shorter than `DEBOUNCE`+1 samples never asserts `C`, and the debounce restarts from zero.
- **Gap restart:** any high `s_sync` sample in SERVE restarts the gap count.
- **Reset mid-operation:** `C` and `car_count` read 0 after the reset edge, whatever the prior state. `sense` then needs the full rising-edge latency again.

## Configuration
- **`CAR_COUNT_EN` defined:**
  - The `car_count` port and an 8-bit counter are compiled in.
  - The counter increments on every QUALIFY→REQUEST transition and saturates at 255.
  - It is cleared only by `reset`.
- **`CAR_COUNT_EN` undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Qualification:** defaults, reset, `sense`=1 held, `FG`=0 → `C`=0 through edge 6, `C`=1 after edge 7, and `C` stays 1 for 50 cycles.
- **Glitch rejection:** `sense` pulses high for 3 cycles, then low for 5, repeated 10 times → `C` stays 0 throughout; `car_count`=0.
- **Service and release:** `C`=1, `FG`←1, `sense`←0 → `C`=0 exactly after edge 5 from the `sense` fall. Add a 2-cycle `sense` blip mid-gap → the gap restarts and the fall is delayed accordingly.
- **Controller time-out:** SERVE with `sense`=1 held, then `FG`←0 → `C`=0 one edge later. `C` re-asserts `DEBOUNCE`+1 edges after returning to IDLE, and `car_count` increments to 2.
- **Reset mid-REQUEST:** `C`=1 and `reset` pulsed for 1 cycle while `sense`=1 → `C`=0 after the reset edge, and `C`=1 again `DEBOUNCE`+3 edges after reset deasserts.
- **Saturation (`CAR_COUNT_EN`):** 260 qualify/serve/release cycles → `car_count` reads 255 and holds.

Source files
------------

// File: rtl/farm_sensor.sv
// farm_sensor: conditions the raw farm-road loop sensor for the traffic light
// controller. A two-flop synchronizer feeds a four-state FSM that debounces
// arrivals, latches the car-waiting request C and releases it once the farm
// road has had green and the loop has been clear for HOLD samples.
// Optional feature macro: CAR_COUNT_EN adds the saturating car_count output.
module farm_sensor #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned HOLD     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sense,
    input  logic       FG,
    output logic       C
`ifdef CAR_COUNT_EN
    ,
    output logic [7:0] car_count
`endif
);

    if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
        $error("farm_sensor: DEBOUNCE must be in 1..255");
    end
    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("farm_sensor: HOLD must be in 1..255");
    end

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUALIFY = 2'd1;
    localparam logic [1:0] ST_REQUEST = 2'd2;
    localparam logic [1:0] ST_SERVE   = 2'd3;

    localparam logic [7:0] DEB_LIM  = 8'(DEBOUNCE);
    localparam logic [7:0] HOLD_LIM = 8'(HOLD - 1);

    logic [1:0] sync_q;
    logic       s_sync;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       c_q, c_d;

    // Two-flop synchronizer for the asynchronous loop-sensor level.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would collapse the two stages.
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sense};
        end
    end

    assign s_sync = sync_q[1];

    // Next-state logic: debounce in QUALIFY, hold request, gap timing in SERVE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE: begin
                if (s_sync) begin
                    state_d = ST_QUALIFY;
                    cnt_d   = 8'd1;
                end
            end
            ST_QUALIFY: begin
                if (!s_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == DEB_LIM) begin
                    state_d = ST_REQUEST;
                    c_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_REQUEST: begin
                // Request is latched; the loop level is ignored until served.
                if (FG) begin
                    state_d = ST_SERVE;
                    cnt_d   = 8'd0;
                end
            end
            ST_SERVE: begin
                if (!FG) begin
                    // Controller moved on; a car still present re-qualifies.
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    c_d     = 1'b0;
                end else if (s_sync) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == HOLD_LIM) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    c_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                c_d     = 1'b0;
            end
        endcase
    end

    // FSM, shared counter and request registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    assign C = c_q;

`ifdef CAR_COUNT_EN
    logic       qualify_done;
    logic [7:0] car_count_q;

    assign qualify_done = (state_q == ST_QUALIFY) && s_sync && (cnt_q == DEB_LIM);

    // Saturating count of qualified requests, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            car_count_q <= 8'd0;
        end else if (qualify_done && (car_count_q != 8'hFF)) begin
            car_count_q <= car_count_q + 8'd1;
        end
    end

    assign car_count = car_count_q;
`endif

endmodule

// File: tb/tb_farm_sensor.sv
// Directed bench for farm_sensor with default DEBOUNCE=4, HOLD=3.
// Car-count checks are compiled in when CAR_COUNT_EN is defined.
module tb_farm_sensor;

    logic clock = 1'b0;
    logic reset;
    logic sense;
    logic FG;
    logic C;
`ifdef CAR_COUNT_EN
    logic [7:0] car_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cars = 0;

    farm_sensor #(.DEBOUNCE(4), .HOLD(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .sense    (sense),
        .FG       (FG),
        .C        (C)
`ifdef CAR_COUNT_EN
        ,
        .car_count(car_count)
`endif
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag);
`ifdef CAR_COUNT_EN
        check(tag, car_count, 8'(exp_cars));
`else
        check(tag, {7'd0, C}, {7'd0, C === 1'b1 ? 1'b1 : 1'b0});
`endif
    endtask

    initial begin
        reset = 1'b1;
        sense = 1'b0;
        FG    = 1'b0;
        tick();
        tick();
        check("reset_C", {7'd0, C}, 8'd0);
`ifdef CAR_COUNT_EN
        check("reset_count", car_count, 8'd0);
`endif
        reset = 1'b0;
        tick();

        // Glitch rejection: 3 high / 5 low, x10, with FG high (ignored).
        FG = 1'b1;
        for (int r = 0; r < 10; r++) begin
            sense = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                check("glitch_hi", {7'd0, C}, 8'd0);
            end
            sense = 1'b0;
            for (int k = 0; k < 5; k++) begin
                tick();
                check("glitch_lo", {7'd0, C}, 8'd0);
            end
        end
        FG = 1'b0;
        repeat (3) tick();
`ifdef CAR_COUNT_EN
        check("glitch_count", car_count, 8'd0);
`endif

        // Qualification: C low through edge 6, high after edge 7, held 50.
        sense = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("qual_low", {7'd0, C}, 8'd0);
        end
        tick();
        check("qual_rise", {7'd0, C}, 8'd1);
        exp_cars = 1;
        for (int e = 0; e < 50; e++) begin
            tick();
            check("qual_hold", {7'd0, C}, 8'd1);
        end
`ifdef CAR_COUNT_EN
        check("qual_count", car_count, 8'd1);
`endif

        // Service and release: C falls after edge 5 from the sense fall.
        FG = 1'b1;
        tick();
        tick();
        sense = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("release_wait", {7'd0, C}, 8'd1);
        end
        tick();
        check("release_fall", {7'd0, C}, 8'd0);
        FG = 1'b0;
        repeat (3) tick();

        // Re-qualify, then release with a 2-cycle blip: fall moves to edge 9.
        sense = 1'b1;
        repeat (7) tick();
        check("blip_qual", {7'd0, C}, 8'd1);
        exp_cars++;
        FG = 1'b1;
        tick();
        tick();
        sense = 1'b0;
        tick();
        tick();
        sense = 1'b1;
        for (int e = 3; e <= 4; e++) begin
            tick();
            check("blip_wait", {7'd0, C}, 8'd1);
        end
        sense = 1'b0;
        for (int e = 5; e <= 8; e++) begin
            tick();
            check("blip_wait", {7'd0, C}, 8'd1);
        end
        tick();
        check("blip_fall", {7'd0, C}, 8'd0);
        FG = 1'b0;
        repeat (3) tick();

        // Controller time-out with the car still present.
        sense = 1'b1;
        repeat (7) tick();
        check("tmo_qual", {7'd0, C}, 8'd1);
        exp_cars++;
        FG = 1'b1;
        repeat (3) tick();
        check("tmo_serve", {7'd0, C}, 8'd1);
        FG = 1'b0;
        tick();
        check("tmo_fall", {7'd0, C}, 8'd0);
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("tmo_requal_low", {7'd0, C}, 8'd0);
        end
        tick();
        check("tmo_requal_rise", {7'd0, C}, 8'd1);
        exp_cars++;
        check_count("tmo_count");

        // Reset in REQUEST with sense held high.
        reset = 1'b1;
        tick();
        check("rst_mid_C", {7'd0, C}, 8'd0);
        exp_cars = 0;
        check_count("rst_mid_count");
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("rst_requal_low", {7'd0, C}, 8'd0);
        end
        tick();
        check("rst_requal_rise", {7'd0, C}, 8'd1);
        exp_cars = 1;
        check_count("rst_requal_count");

`ifdef CAR_COUNT_EN
        // Saturation: serve/release the pending car, then 260 full cycles.
        FG = 1'b1;
        tick();
        sense = 1'b0;
        repeat (5) tick();
        FG = 1'b0;
        tick();
        check("sat_start", {7'd0, C}, 8'd0);
        for (int n = 0; n < 260; n++) begin
            sense = 1'b1;
            repeat (7) tick();
            FG = 1'b1;
            tick();
            sense = 1'b0;
            repeat (5) tick();
            FG = 1'b0;
            tick();
        end
        check("sat_C", {7'd0, C}, 8'd0);
        check("sat_count", car_count, 8'd255);
        sense = 1'b1;
        repeat (7) tick();
        check("sat_hold_C", {7'd0, C}, 8'd1);
        check("sat_hold_count", car_count, 8'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
